// File: rtl/xadc_sample_avg.sv
// Box-car averager for one XADC channel: averages 2^AVG_LOG2 DRP conversions and drives a
// hysteresis alarm and a 16-LED thermometer bargraph. Define XADC_PEAK_HOLD_EN for peak hold.
module xadc_sample_avg #(
  parameter logic [4:0]  CHANNEL   = 5'h12,
  parameter int unsigned AVG_LOG2  = 4,
  parameter logic [11:0] THRESH_HI = 12'hC00,
  parameter logic [11:0] THRESH_LO = 12'h800
) (
  input  logic        CLK100MHZ,
  input  logic        reset_in,
  input  logic        drdy_in,
  input  logic [15:0] do_in,
  input  logic [4:0]  channel_in,
  input  logic        clear_in,
  output logic [11:0] avg_out,
  output logic        avg_valid,
  output logic        alarm_out,
  output logic [15:0] LED,
  output logic [11:0] peak_out
);

  localparam int unsigned AccW = 12 + AVG_LOG2;
  localparam int unsigned CntW = (AVG_LOG2 == 0) ? 1 : AVG_LOG2;
  localparam logic [CntW-1:0] CntLast = CntW'((32'd1 << AVG_LOG2) - 32'd1);

  typedef enum logic [0:0] {StAccum, StEmit} state_e;

  state_e          state_q, state_d;
  logic [AccW-1:0] acc_q, acc_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [11:0]     avg_q;
  logic            alarm_q, alarm_d;
  logic [15:0]     led_q, led_d;

  logic [11:0]     sample;
  logic [AccW-1:0] sum;
  logic [11:0]     avg_new;
  logic            accept;
  logic            load;
  logic            unused_do_lsb;

  assign sample        = do_in[15:4];
  assign unused_do_lsb = ^do_in[3:0];
  assign accept        = drdy_in && (channel_in == CHANNEL) && !clear_in;
  assign load          = accept && (cnt_q == CntLast);
  // The accumulator is exactly 12+AVG_LOG2 wide, so its top 12 bits are the truncated mean.
  assign sum           = acc_q + AccW'(sample);
  assign avg_new       = sum[AccW-1 -: 12];

  always_comb begin
    state_d = StAccum;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      // An accept during EMIT is simply the first sample of the next block.
      StAccum, StEmit: state_d = load ? StEmit : StAccum;
      default:         state_d = StAccum;
    endcase
    if (clear_in) begin
      acc_d = '0;
      cnt_d = '0;
    end else if (accept) begin
      if (load) begin
        acc_d = '0;
        cnt_d = '0;
      end else begin
        acc_d = sum;
        cnt_d = cnt_q + CntW'(1);
      end
    end
  end

  always_comb begin
    alarm_d = alarm_q;
    if (avg_new > THRESH_HI) begin
      alarm_d = 1'b1;
    end else if (avg_new < THRESH_LO) begin
      alarm_d = 1'b0;
    end
    led_d = '0;
    for (int i = 0; i < 16; i++) begin
      led_d[i] = avg_new > 12'(i * 256);
    end
  end

  always_ff @(posedge CLK100MHZ or posedge reset_in) begin
    if (reset_in) begin
      state_q <= StAccum;
      acc_q   <= '0;
      cnt_q   <= '0;
      avg_q   <= '0;
      alarm_q <= 1'b0;
      led_q   <= '0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      if (load) begin
        avg_q   <= avg_new;
        alarm_q <= alarm_d;
        led_q   <= led_d;
      end
    end
  end

  assign avg_out   = avg_q;
  assign avg_valid = (state_q == StEmit);
  assign alarm_out = alarm_q;
  assign LED       = led_q;

`ifdef XADC_PEAK_HOLD_EN
  logic [11:0] peak_q;

  always_ff @(posedge CLK100MHZ or posedge reset_in) begin
    if (reset_in) begin
      peak_q <= '0;
    end else if (clear_in) begin
      peak_q <= '0;
    end else if (load && (avg_new > peak_q)) begin
      peak_q <= avg_new;
    end
  end

  assign peak_out = peak_q;
`else
  assign peak_out = 12'h000;
`endif

endmodule
